stereo_delay_fb: RTL and testbench

Stereo feedback-delay audio effect: the processing stage between the I2S receiver and the I2S transmitter. Once per audio frame it takes the parallel left/right samples from the receiver, reads a delayed sample per channel from a circular buffer, and writes back the input plus a scaled feedback term. It drives the transmitter's parallel inputs with dry plus scaled delayed signal. Runs entirely in the codec bit-clock domain.

---
 rtl/stereo_delay_fb_pkg.sv | 27 ++
 rtl/stereo_delay_fb_delay_ram.sv | 24 ++
 rtl/stereo_delay_fb.sv | 201 ++++++++++++++++++++
 tb/tb_stereo_delay_fb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/stereo_delay_fb_pkg.sv
// Shared audio definitions: sample and gain widths, accumulator width and
// the saturating narrow from the MAC accumulator to a sample.
package stereo_delay_fb_pkg;

    localparam int SAMPLE_W = 16;
    localparam int GAIN_W   = 8;
    localparam int ACC_W    = SAMPLE_W + GAIN_W + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    // Clamp a signed accumulator value into the signed sample range.
    function automatic logic [SAMPLE_W-1:0] sat_sample(input logic signed [ACC_W-1:0] x);
        logic [SAMPLE_W-1:0] y;
        if (x > SAT_MAX) begin
            y = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (x < SAT_MIN) begin
            y = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            y = x[SAMPLE_W-1:0];
        end
        return y;
    endfunction

endpackage

// File: rtl/stereo_delay_fb_delay_ram.sv
// Single-port synchronous RAM, read-first, one-cycle read latency.
// Contents are deliberately not reset so the array maps onto block RAM.
module delay_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];

    // Synchronous write and registered read on the shared address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/stereo_delay_fb.sv
// Stereo feedback delay: per frame reads a delayed sample per channel, writes
// back input plus scaled feedback, and outputs dry plus scaled delayed signal.
module stereo_delay_fb
    import stereo_delay_fb_pkg::*;
#(
    parameter int BITSIZE  = SAMPLE_W,
    parameter int ADDRBITS = 12
) (
    input  logic                bclk,
    input  logic                rst,
    input  logic                lrclk,
    input  logic [BITSIZE-1:0]  left_in,
    input  logic [BITSIZE-1:0]  right_in,
    input  logic [ADDRBITS-1:0] delay,
    input  logic [GAIN_W-1:0]   feedback,
    input  logic [GAIN_W-1:0]   mix,
    output logic [BITSIZE-1:0]  left_out,
    output logic [BITSIZE-1:0]  right_out,
    output logic                ready
);

    localparam logic [3:0] S_CLEAR = 4'd0;
    localparam logic [3:0] S_IDLE  = 4'd1;
    localparam logic [3:0] S_RD_L  = 4'd2;
    localparam logic [3:0] S_MAC_L = 4'd3;
    localparam logic [3:0] S_WR_L  = 4'd4;
    localparam logic [3:0] S_RD_R  = 4'd5;
    localparam logic [3:0] S_MAC_R = 4'd6;
    localparam logic [3:0] S_WR_R  = 4'd7;
    localparam logic [3:0] S_OUT   = 4'd8;

    localparam int RAM_AW = ADDRBITS + 1;
    localparam logic [RAM_AW-1:0]   CLR_LAST = {RAM_AW{1'b1}};
    localparam logic [RAM_AW-1:0]   CLR_ONE  = {{(RAM_AW-1){1'b0}}, 1'b1};
    localparam logic [ADDRBITS-1:0] PTR_ONE  = {{(ADDRBITS-1){1'b0}}, 1'b1};

    logic [3:0]          state_r;
    logic [RAM_AW-1:0]   clr_cnt_r;
    logic [ADDRBITS-1:0] wr_ptr_r;
    logic                lrclk_q_r;
    logic                arm_r;
    logic [BITSIZE-1:0]  dry_l_r;
    logic [BITSIZE-1:0]  dry_r_r;
    logic [BITSIZE-1:0]  wet_l_r;
    logic [BITSIZE-1:0]  wet_r_r;
    logic [BITSIZE-1:0]  fbv_r;

    logic                strobe_s;
    logic [ADDRBITS-1:0] rd_ptr_s;
    logic                ram_we_s;
    logic [RAM_AW-1:0]   ram_addr_s;
    logic [BITSIZE-1:0]  ram_wdata_s;
    logic [BITSIZE-1:0]  ram_rdata_s;

    logic [BITSIZE-1:0]      dry_sel_s;
    logic signed [ACC_W-1:0] w_ext_s;
    logic signed [ACC_W-1:0] dry_ext_s;
    logic signed [ACC_W-1:0] fb_ext_s;
    logic signed [ACC_W-1:0] mix_ext_s;
    logic signed [ACC_W-1:0] prod_fb_s;
    logic signed [ACC_W-1:0] prod_mix_s;
    logic signed [ACC_W-1:0] sum_fb_s;
    logic signed [ACC_W-1:0] sum_mix_s;

    assign strobe_s = lrclk & ~lrclk_q_r;
    // Modular subtraction; delay 0 lands on wr_ptr itself, read before write.
    assign rd_ptr_s = wr_ptr_r - delay;

    // Gains are unsigned, so they enter the signed multiply zero-extended.
    assign dry_sel_s  = (state_r == S_MAC_R) ? dry_r_r : dry_l_r;
    assign w_ext_s    = {{(ACC_W-BITSIZE){ram_rdata_s[BITSIZE-1]}}, ram_rdata_s};
    assign dry_ext_s  = {{(ACC_W-BITSIZE){dry_sel_s[BITSIZE-1]}}, dry_sel_s};
    assign fb_ext_s   = {{(ACC_W-GAIN_W){1'b0}}, feedback};
    assign mix_ext_s  = {{(ACC_W-GAIN_W){1'b0}}, mix};
    assign prod_fb_s  = w_ext_s * fb_ext_s;
    assign prod_mix_s = w_ext_s * mix_ext_s;
    assign sum_fb_s   = dry_ext_s + (prod_fb_s >>> GAIN_W);
    assign sum_mix_s  = dry_ext_s + (prod_mix_s >>> GAIN_W);

    // RAM port steering: clear sweep, delayed reads, feedback writes.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = {RAM_AW{1'b0}};
        ram_wdata_s = {BITSIZE{1'b0}};
        case (state_r)
            S_CLEAR: begin
                ram_we_s   = 1'b1;
                ram_addr_s = clr_cnt_r;
            end
            S_RD_L: begin
                ram_addr_s = {rd_ptr_s, 1'b0};
            end
            S_WR_L: begin
                ram_we_s    = 1'b1;
                ram_addr_s  = {wr_ptr_r, 1'b0};
                ram_wdata_s = fbv_r;
            end
            S_RD_R: begin
                ram_addr_s = {rd_ptr_s, 1'b1};
            end
            S_WR_R: begin
                ram_we_s    = 1'b1;
                ram_addr_s  = {wr_ptr_r, 1'b1};
                ram_wdata_s = fbv_r;
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    // Frame sequencer, pointers, MAC result registers and output registers.
    always_ff @(posedge bclk) begin
        if (rst) begin
            state_r   <= S_CLEAR;
            clr_cnt_r <= {RAM_AW{1'b0}};
            wr_ptr_r  <= {ADDRBITS{1'b0}};
            lrclk_q_r <= 1'b0;
            arm_r     <= 1'b0;
            dry_l_r   <= {BITSIZE{1'b0}};
            dry_r_r   <= {BITSIZE{1'b0}};
            wet_l_r   <= {BITSIZE{1'b0}};
            wet_r_r   <= {BITSIZE{1'b0}};
            fbv_r     <= {BITSIZE{1'b0}};
            left_out  <= {BITSIZE{1'b0}};
            right_out <= {BITSIZE{1'b0}};
            ready     <= 1'b0;
        end else begin
            lrclk_q_r <= lrclk;
            case (state_r)
                S_CLEAR: begin
                    if (clr_cnt_r == CLR_LAST) begin
                        clr_cnt_r <= {RAM_AW{1'b0}};
                        ready     <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + CLR_ONE;
                    end
                end
                // The strobe cycle only captures the inputs; the frame starts next cycle.
                S_IDLE: begin
                    if (arm_r) begin
                        arm_r   <= 1'b0;
                        state_r <= S_RD_L;
                    end else if (strobe_s) begin
                        dry_l_r <= left_in;
                        dry_r_r <= right_in;
                        arm_r   <= 1'b1;
                    end else begin
                        arm_r <= 1'b0;
                    end
                end
                S_RD_L: begin
                    state_r <= S_MAC_L;
                end
                S_MAC_L: begin
                    fbv_r   <= sat_sample(sum_fb_s);
                    wet_l_r <= sat_sample(sum_mix_s);
                    state_r <= S_WR_L;
                end
                S_WR_L: begin
                    state_r <= S_RD_R;
                end
                S_RD_R: begin
                    state_r <= S_MAC_R;
                end
                S_MAC_R: begin
                    fbv_r   <= sat_sample(sum_fb_s);
                    wet_r_r <= sat_sample(sum_mix_s);
                    state_r <= S_WR_R;
                end
                S_WR_R: begin
                    state_r <= S_OUT;
                end
                S_OUT: begin
                    left_out  <= wet_l_r;
                    right_out <= wet_r_r;
                    wr_ptr_r  <= wr_ptr_r + PTR_ONE;
                    state_r   <= S_IDLE;
                end
                default: begin
                    state_r   <= S_CLEAR;
                    clr_cnt_r <= {RAM_AW{1'b0}};
                    ready     <= 1'b0;
                end
            endcase
        end
    end

    delay_ram #(
        .DATA_W(BITSIZE),
        .ADDR_W(RAM_AW)
    ) u_delay_ram (
        .clk  (bclk),
        .we   (ram_we_s),
        .addr (ram_addr_s),
        .wdata(ram_wdata_s),
        .rdata(ram_rdata_s)
    );

endmodule

// File: tb/tb_stereo_delay_fb.sv
// Directed bench for stereo_delay_fb with ADDRBITS=4: a behavioural delay-line
// model feeds a scoreboard queue that is checked at each output update.
module tb_stereo_delay_fb;

    localparam int AB    = 4;
    localparam int DEPTH = 16;

    logic        bclk = 1'b0;
    logic        rst = 1'b1;
    logic        lrclk = 1'b0;
    logic [15:0] left_in = 16'h0000;
    logic [15:0] right_in = 16'h0000;
    logic [3:0]  delay = 4'd1;
    logic [7:0]  feedback = 8'd0;
    logic [7:0]  mix = 8'd0;
    logic [15:0] left_out;
    logic [15:0] right_out;
    logic        ready;

    int checks = 0;
    int failures = 0;

    int          buf_l [DEPTH];
    int          buf_r [DEPTH];
    int          mptr;
    logic [31:0] exp_q [$];
    logic [15:0] prev_l;
    logic [15:0] prev_r;

    always #5 bclk = ~bclk;

    stereo_delay_fb #(.BITSIZE(16), .ADDRBITS(AB)) dut (
        .bclk(bclk), .rst(rst), .lrclk(lrclk),
        .left_in(left_in), .right_in(right_in),
        .delay(delay), .feedback(feedback), .mix(mix),
        .left_out(left_out), .right_out(right_out), .ready(ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int x);
        if (x > 32767) return 32767;
        else if (x < -32768) return -32768;
        else return x;
    endfunction

    // dry + floor(w*g/256), saturated
    function automatic int mac(input int dry, input int w, input int g);
        int p, q;
        p = w * g;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return sat16(dry + q);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            buf_l[i] = 0;
            buf_r[i] = 0;
        end
        mptr = 0;
        exp_q.delete();
        prev_l = 16'h0000;
        prev_r = 16'h0000;
    endtask

    task automatic model_push(input logic [15:0] l, input logic [15:0] r);
        int d, rd, dl, dr, el, er, fl, fr;
        d  = (delay == 4'd0) ? DEPTH : int'(delay);
        rd = (mptr - d + DEPTH) % DEPTH;
        dl = int'($signed(l));
        dr = int'($signed(r));
        el = mac(dl, buf_l[rd], int'(mix));
        er = mac(dr, buf_r[rd], int'(mix));
        fl = mac(dl, buf_l[rd], int'(feedback));
        fr = mac(dr, buf_r[rd], int'(feedback));
        buf_l[mptr] = fl;
        buf_r[mptr] = fr;
        mptr = (mptr + 1) % DEPTH;
        exp_q.push_back({el[15:0], er[15:0]});
    endtask

    // Counts edges after the reset edge until ready; strobes are toggled meanwhile.
    task automatic wait_clear(input string tag);
        int cnt;
        check({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
        check({tag, "_left_zero"}, {16'd0, left_out}, 32'd0);
        check({tag, "_right_zero"}, {16'd0, right_out}, 32'd0);
        cnt = 0;
        left_in = 16'h1234;
        right_in = 16'h4321;
        while (!ready && cnt < 100) begin
            lrclk = ((cnt % 8) < 4);
            @(posedge bclk);
            #1;
            cnt++;
        end
        check({tag, "_clear_cycles"}, cnt, 32'd32);
        lrclk = 1'b0;
        left_in = 16'h0000;
        right_in = 16'h0000;
        repeat (4) @(posedge bclk);
        #1;
        check({tag, "_left_after_clear"}, {16'd0, left_out}, 32'd0);
        check({tag, "_right_after_clear"}, {16'd0, right_out}, 32'd0);
        model_reset();
    endtask

    task automatic do_reset(input string tag);
        @(posedge bclk);
        #1 rst = 1'b1;
        @(posedge bclk);
        #1 rst = 1'b0;
        wait_clear(tag);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] l, input logic [15:0] r);
        logic [31:0] e;
        model_push(l, r);
        @(posedge bclk);
        #1;
        left_in = l;
        right_in = r;
        lrclk = 1'b1;
        @(posedge bclk);
        repeat (7) @(posedge bclk);
        #1;
        check({tag, "_hold_l"}, {16'd0, left_out}, {16'd0, prev_l});
        check({tag, "_hold_r"}, {16'd0, right_out}, {16'd0, prev_r});
        @(posedge bclk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_left"}, {16'd0, left_out}, {16'd0, e[31:16]});
        check({tag, "_right"}, {16'd0, right_out}, {16'd0, e[15:0]});
        prev_l = e[31:16];
        prev_r = e[15:0];
        repeat (22) @(posedge bclk);
        #1 lrclk = 1'b0;
        repeat (31) @(posedge bclk);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge bclk);
        #1 rst = 1'b0;
        wait_clear("por");
        do_reset("pulse");

        // Impulse echo at 3 frames, half wet gain, no feedback.
        delay = 4'd3; mix = 8'd128; feedback = 8'd0;
        run_frame("imp0", 16'h4000, 16'h0000);
        for (int i = 1; i < 6; i++) run_frame("imp", 16'h0000, 16'h0000);

        // Feedback chain halving every 2 frames.
        do_reset("rst_fb");
        delay = 4'd2; mix = 8'd255; feedback = 8'd128;
        run_frame("fb0", 16'h4000, 16'h0000);
        for (int i = 1; i < 7; i++) run_frame("fb", 16'h0000, 16'h0000);

        // Saturation toward both rails, channels driven in opposite sense.
        do_reset("rst_sat");
        delay = 4'd1; mix = 8'd255; feedback = 8'd255;
        for (int i = 0; i < 3; i++) run_frame("satp", 16'h7000, 16'h9000);
        for (int i = 0; i < 5; i++) run_frame("satn", 16'h9000, 16'h7000);

        // delay=0 gives a full 16-frame echo.
        do_reset("rst_wrap");
        delay = 4'd0; mix = 8'd255; feedback = 8'd0;
        run_frame("wrap0", 16'h4000, 16'hC000);
        for (int i = 1; i < 18; i++) run_frame("wrap", 16'h0000, 16'h0000);

        // Reset asserted during MAC_R of a loud frame.
        do_reset("rst_mid");
        delay = 4'd1; mix = 8'd255; feedback = 8'd255;
        run_frame("loud", 16'h7000, 16'h7000);
        @(posedge bclk);
        #1;
        left_in = 16'h7000;
        right_in = 16'h7000;
        lrclk = 1'b1;
        @(posedge bclk);
        repeat (5) @(posedge bclk);
        #1 rst = 1'b1;
        @(posedge bclk);
        #1 rst = 1'b0;
        lrclk = 1'b0;
        wait_clear("midrst");
        delay = 4'd1;
        for (int i = 0; i < 3; i++) run_frame("post_d1", 16'h0000, 16'h0000);
        delay = 4'd3;
        for (int i = 0; i < 3; i++) run_frame("post_d3", 16'h0000, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
